dmem_responder: RTL and testbench

Data-memory responder for the pipelined CPU's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. Stores are committed with byte enables; loads and stores both return a response over a second valid/ready handshake. The block also emits a one-cycle store trace pulse so the bench can compare commit logs against a reference model.

---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 129 ++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// full-word byte-enable constant, word-index extraction and byte merge.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

  // Byte i of the result comes from new_word when be[i] is set, else from old_word.
  function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous clear-to-zero, combinational read,
// synchronous byte-enable write.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [31:0]           rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [3:0]            wr_be_i,
  input  logic [31:0]           wr_data_i
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= merge_be(mem_q[wr_addr_i], wr_data_i, wr_be_i);
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: one request at a time, WAIT_CYCLES wait states,
// byte-merged store commit with trace pulse, response over valid/ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam logic [3:0]  CNT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [30:0] DEPTH    = 31'(1) << ADDR_WIDTH;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic                  accept;
  logic                  commit;
  logic                  err;
  logic                  wr_en;
  logic [29:0]           widx;
  logic [ADDR_WIDTH-1:0] mem_idx;
  logic [31:0]           rd_word;
  logic [31:0]           merged;

  assign widx    = word_index(addr_q);
  assign mem_idx = widx[ADDR_WIDTH-1:0];
  // Full 30-bit compare so high address bits never alias into the array.
  assign err     = (addr_q[1:0] != 2'b00) || ({1'b0, widx} >= DEPTH);
  assign commit  = (state_q == ST_COMMIT);
  assign wr_en   = commit && write_q && !err;
  assign merged  = merge_be(rd_word, wdata_q, be_q);
  assign accept  = (state_q == ST_IDLE) && req_valid;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_i (mem_idx),
    .rd_data_o (rd_word),
    .wr_en_i   (wr_en),
    .wr_addr_i (mem_idx),
    .wr_be_i   (be_q),
    .wr_data_i (wdata_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? ST_BUSY : ST_COMMIT;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      pc_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        pc_q    <= req_pc;
      end
      if (commit) begin
        rdata_q <= (!write_q && !err) ? rd_word : 32'd0;
        err_q   <= err;
      end
    end
  end

  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign trace_valid = wr_en;
  assign trace_pc    = pc_q;
  assign trace_addr  = addr_q;
  assign trace_data  = merged;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states,
// one with none, checked against hand-computed expectations.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: WAIT_CYCLES=2
  logic        req_valid = 0, req_write = 0, resp_ready = 1;
  logic [31:0] req_addr = 0, req_wdata = 0, req_pc = 0;
  logic [3:0]  req_be = 0;
  logic        req_ready, resp_valid, resp_err, trace_valid;
  logic [31:0] resp_rdata, trace_pc, trace_addr, trace_data;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  // Instance B: WAIT_CYCLES=0
  logic        b_req_valid = 0, b_req_write = 0, b_resp_ready = 1;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_req_pc = 0;
  logic [3:0]  b_req_be = 0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_trace_valid;
  logic [31:0] b_resp_rdata, b_trace_pc, b_trace_addr, b_trace_data;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be), .req_pc(b_req_pc),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .trace_valid(b_trace_valid), .trace_pc(b_trace_pc),
    .trace_addr(b_trace_addr), .trace_data(b_trace_data)
  );

  // Trace log of instance A
  int          tr_cnt = 0;
  logic [31:0] tr_pc = 0, tr_addr = 0, tr_data = 0;
  always @(negedge clk) begin
    if (trace_valid) begin
      tr_cnt  <= tr_cnt + 1;
      tr_pc   <= trace_pc;
      tr_addr <= trace_addr;
      tr_data <= trace_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request on instance A with resp_ready high; returns the response
  // and the cycle distance from the accept cycle to the first resp_valid cycle.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] pc,
                        output logic [31:0] rdata, output logic err, output int lat);
    int  acc;
    bit  ok;
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata;
    req_be = be; req_pc = pc; resp_ready = 1;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    check("accept", 32'(ok), 32'd1);
    acc = cyc;
    @(negedge clk);
    req_valid = 0;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) begin lat = cyc - acc; break; end
      @(negedge clk);
    end
    rdata = resp_rdata;
    err   = resp_err;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, t0;
  int          acc_c[8], rsp_c[8];
  logic [31:0] rsp_d[8];
  int          na, nr;
  bit          seen;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Reset state
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_trace_valid", 32'(trace_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_trace_pc", trace_pc, 32'd0);
    check("rst_trace_addr", trace_addr, 32'd0);
    check("rst_trace_data", trace_data, 32'd0);

    // Full-word store then load
    t0 = tr_cnt;
    do_req(1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h100, rd, er, lat);
    check("t1_st_lat", 32'(lat), 32'd4);
    check("t1_st_err", 32'(er), 32'd0);
    check("t1_st_rdata", rd, 32'd0);
    check("t1_tr_cnt", 32'(tr_cnt - t0), 32'd1);
    check("t1_tr_addr", tr_addr, 32'h10);
    check("t1_tr_data", tr_data, 32'hDEADBEEF);
    check("t1_tr_pc", tr_pc, 32'h100);
    do_req(0, 32'h10, 32'h0, 4'b0000, 32'h104, rd, er, lat);
    check("t1_ld_lat", 32'(lat), 32'd4);
    check("t1_ld_err", 32'(er), 32'd0);
    check("t1_ld_rdata", rd, 32'hDEADBEEF);
    check("t1_ld_no_trace", 32'(tr_cnt - t0), 32'd1);

    // Byte merge
    do_req(1, 32'h20, 32'h11223344, 4'b1111, 32'h200, rd, er, lat);
    do_req(1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h204, rd, er, lat);
    check("t2_tr_data", tr_data, 32'h11BB33DD);
    check("t2_tr_pc", tr_pc, 32'h204);
    do_req(0, 32'h20, 32'h0, 4'b0000, 32'h208, rd, er, lat);
    check("t2_ld_rdata", rd, 32'h11BB33DD);

    // Errors and range boundaries
    t0 = tr_cnt;
    do_req(1, 32'h22, 32'hFFFFFFFF, 4'b1111, 32'h300, rd, er, lat);
    check("t3_mis_err", 32'(er), 32'd1);
    check("t3_mis_no_trace", 32'(tr_cnt - t0), 32'd0);
    do_req(0, 32'h20, 32'h0, 4'b1111, 32'h304, rd, er, lat);
    check("t3_mis_mem", rd, 32'h11BB33DD);
    do_req(0, 32'h4000, 32'h0, 4'b1111, 32'h308, rd, er, lat);
    check("t3_oor_err", 32'(er), 32'd1);
    check("t3_oor_rdata", rd, 32'd0);
    do_req(0, 32'h3FFC, 32'h0, 4'b1111, 32'h30C, rd, er, lat);
    check("t3_top_err", 32'(er), 32'd0);
    do_req(1, 32'h20, 32'hFFFFFFFF, 4'b0000, 32'h310, rd, er, lat);
    check("t3_be0_err", 32'(er), 32'd0);
    check("t3_be0_trace", 32'(tr_cnt - t0), 32'd1);
    check("t3_be0_tr_data", tr_data, 32'h11BB33DD);
    do_req(0, 32'h20, 32'h0, 4'b0000, 32'h314, rd, er, lat);
    check("t3_be0_mem", rd, 32'h11BB33DD);

    // Backpressure with req_valid held high
    @(negedge clk);
    resp_ready = 0;
    req_valid = 1; req_write = 0; req_addr = 32'h10; req_be = 4'b1111; req_pc = 32'h400;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t4_resp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_hold_valid", 32'(resp_valid), 32'd1);
      check("t4_hold_rdata", resp_rdata, 32'hDEADBEEF);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    resp_ready = 1;
    check("t4_release_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t4_idle_ready", 32'(req_ready), 32'd1);
    check("t4_idle_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("t4_reaccepted", 32'(req_ready), 32'd0);
    req_valid = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t4_second_rdata", resp_rdata, 32'hDEADBEEF);

    // Reset during BUSY of a store
    @(negedge clk);
    t0 = tr_cnt;
    req_valid = 1; req_write = 1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    req_be = 4'b1111; req_pc = 32'h500;
    check("t5_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("t5_rst_ready", 32'(req_ready), 32'd1);
    check("t5_rst_valid", 32'(resp_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("t5_no_trace", 32'(tr_cnt - t0), 32'd0);
    do_req(0, 32'h30, 32'h0, 4'b1111, 32'h504, rd, er, lat);
    check("t5_ld_rdata", rd, 32'd0);
    check("t5_ld_lat", 32'(lat), 32'd4);

    // Zero wait states: store then back-to-back loads, resp_ready high
    na = 0; nr = 0;
    @(negedge clk);
    b_resp_ready = 1;
    b_req_valid = 1; b_req_write = 1; b_req_addr = 32'h8;
    b_req_wdata = 32'h12345678; b_req_be = 4'b1111; b_req_pc = 32'h600;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (b_req_valid && b_req_ready && na < 8) begin acc_c[na] = cyc; na++; end
      if (b_resp_valid && nr < 8) begin rsp_c[nr] = cyc; rsp_d[nr] = b_resp_rdata; nr++; end
      if (i == 1) b_req_write = 0;
    end
    b_req_valid = 0;
    check("t6_n_acc", 32'(na >= 4), 32'd1);
    check("t6_n_rsp", 32'(nr >= 4), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("t6_lat", 32'(rsp_c[k] - acc_c[k]), 32'd2);
      if (k > 0) begin
        check("t6_period", 32'(acc_c[k] - acc_c[k-1]), 32'd3);
        check("t6_rdata", rsp_d[k], 32'h12345678);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
